// File: rtl/mac8_signed_dot.sv
// Streaming signed dot-product engine: an operand register feeds an 8x8 signed multiplier,
// and the products are accumulated into one registered result per in_last-delimited vector.

module multiply8_signed_structural (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] prod_o
);
    logic [15:0] aExt;
    logic [15:0] partialRow [8];

    assign aExt = {{8{a_i[7]}}, a_i};

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            partialRow[i] = b_i[i] ? (aExt << i) : 16'd0;
        end
    end

    // Row 7 carries the negative weight of b's sign bit, so it is subtracted.
    always_comb begin
        prod_o = 16'd0;
        for (int i = 0; i < 7; i++) begin
            prod_o = prod_o + partialRow[i];
        end
        prod_o = prod_o - partialRow[7];
    end
endmodule

module mac8_signed_dot #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_overflow
);
    logic             v1_q, v1_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic             last_q, last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             outValid_q, outValid_d;
    logic [ACC_W-1:0] outSum_q, outSum_d;
    logic [7:0]       outCount_q, outCount_d;
    logic             outOverflow_q, outOverflow_d;

    logic [15:0]      prod;
    logic [ACC_W-1:0] prodExt;
    logic [ACC_W-1:0] sumNext;
    logic             ovfNow;
    logic [7:0]       cntInc;
    logic             stall;
    logic             accept;
    logic             step;

    multiply8_signed_structural uMult (
        .a_i    (a_q),
        .b_i    (b_q),
        .prod_o (prod)
    );

    assign prodExt  = ACC_W'($signed(prod));
    assign sumNext  = acc_q + prodExt;
    assign ovfNow   = (acc_q[ACC_W-1] == prodExt[ACC_W-1]) && (sumNext[ACC_W-1] != acc_q[ACC_W-1]);
    assign cntInc   = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

    // Only a finished vector blocked by an unconsumed result can stall; non-last terms always drain.
    assign stall    = v1_q & last_q & outValid_q & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign step     = v1_q & ~stall;

    always_comb begin
        v1_d          = v1_q;
        a_d           = a_q;
        b_d           = b_q;
        last_d        = last_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        outValid_d    = outValid_q;
        outSum_d      = outSum_q;
        outCount_d    = outCount_q;
        outOverflow_d = outOverflow_q;

        if (accept) begin
            v1_d   = 1'b1;
            a_d    = in_a;
            b_d    = in_b;
            last_d = in_last;
        end else if (!stall) begin
            v1_d = 1'b0;
        end

        if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end

        // A result loading on the same edge as a consumption wins over the clear above.
        if (step) begin
            if (last_q) begin
                outValid_d    = 1'b1;
                outSum_d      = sumNext;
                outCount_d    = cntInc;
                outOverflow_d = ovf_q | ovfNow;
                acc_d         = '0;
                cnt_d         = 8'd0;
                ovf_d         = 1'b0;
            end else begin
                acc_d = sumNext;
                cnt_d = cntInc;
                ovf_d = ovf_q | ovfNow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q          <= 1'b0;
            a_q           <= 8'd0;
            b_q           <= 8'd0;
            last_q        <= 1'b0;
            acc_q         <= '0;
            cnt_q         <= 8'd0;
            ovf_q         <= 1'b0;
            outValid_q    <= 1'b0;
            outSum_q      <= '0;
            outCount_q    <= 8'd0;
            outOverflow_q <= 1'b0;
        end else begin
            v1_q          <= v1_d;
            a_q           <= a_d;
            b_q           <= b_d;
            last_q        <= last_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            outValid_q    <= outValid_d;
            outSum_q      <= outSum_d;
            outCount_q    <= outCount_d;
            outOverflow_q <= outOverflow_d;
        end
    end

    assign out_valid    = outValid_q;
    assign out_sum      = outSum_q;
    assign out_count    = outCount_q;
    assign out_overflow = outOverflow_q;
endmodule

// File: tb/tb_mac8_signed_dot.sv
// Bench for mac8_signed_dot: a 24-bit and a 16-bit instance share one stimulus stream and are
// both scored against an arithmetic model of the dot product, plus directed scenario checks.

module tb_mac8_signed_dot;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        inReady24, outValid24, outOverflow24;
    logic [23:0] outSum24;
    logic [7:0]  outCount24;
    logic        inReady16, outValid16, outOverflow16;
    logic [15:0] outSum16;
    logic [7:0]  outCount16;

    int checks = 0;
    int failures = 0;

    typedef struct {
        longint sum;
        int     count;
        bit     ovf;
    } result_t;

    result_t q0[$];
    result_t q1[$];
    longint  accM[2];
    int      cntM[2];
    bit      ovfM[2];
    int      widthM[2] = '{24, 16};
    bit      lastAccepted;

    mac8_signed_dot #(.ACC_W(24)) dut24 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady24),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(outValid24),
        .out_ready(out_ready), .out_sum(outSum24), .out_count(outCount24),
        .out_overflow(outOverflow24)
    );

    mac8_signed_dot #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady16),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(outValid16),
        .out_ready(out_ready), .out_sum(outSum16), .out_count(outCount16),
        .out_overflow(outOverflow16)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 2; i++) begin
            accM[i] = 0;
            cntM[i] = 0;
            ovfM[i] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Exact integer sum, folded back into the signed ACC_W range whenever it leaves it.
    task automatic modelTerm(input int idx, input longint a, input longint b, input bit last);
        longint  one = 1;
        longint  span = one << widthM[idx];
        longint  hi = (one << (widthM[idx] - 1)) - 1;
        longint  lo = -(one << (widthM[idx] - 1));
        longint  t = accM[idx] + a * b;
        result_t r;
        if (t > hi) begin
            t = t - span;
            ovfM[idx] = 1'b1;
        end else if (t < lo) begin
            t = t + span;
            ovfM[idx] = 1'b1;
        end
        cntM[idx] = (cntM[idx] >= 255) ? 255 : cntM[idx] + 1;
        if (last) begin
            r.sum = t;
            r.count = cntM[idx];
            r.ovf = ovfM[idx];
            if (idx == 0) q0.push_back(r);
            else q1.push_back(r);
            accM[idx] = 0;
            cntM[idx] = 0;
            ovfM[idx] = 1'b0;
        end else begin
            accM[idx] = t;
        end
    endtask

    task automatic observeInst(input int idx, input bit valid, input longint sum,
                               input longint count, input bit ovf);
        result_t e;
        int      n = (idx == 0) ? q0.size() : q1.size();
        if (!valid) return;
        if (n == 0) begin
            checkOutput($sformatf("spurious_valid_w%0d", widthM[idx]), valid, 0);
            return;
        end
        e = (idx == 0) ? q0[0] : q1[0];
        checkOutput($sformatf("sum_w%0d", widthM[idx]), sum, e.sum);
        if (out_ready) begin
            checkOutput($sformatf("count_w%0d", widthM[idx]), count, e.count);
            checkOutput($sformatf("ovf_w%0d", widthM[idx]), ovf, e.ovf);
            if (idx == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
        end
    endtask

    task automatic applyStimulus(input bit v, input int a, input int b, input bit last, input bit ordy);
        bit acc0, acc1;
        @(negedge clk);
        in_valid  = v;
        in_a      = 8'(a);
        in_b      = 8'(b);
        in_last   = last;
        out_ready = ordy;
        #1;
        observeInst(0, outValid24, longint'($signed(outSum24)), outCount24, outOverflow24);
        observeInst(1, outValid16, longint'($signed(outSum16)), outCount16, outOverflow16);
        acc0 = in_valid & inReady24;
        acc1 = in_valid & inReady16;
        if (acc0) modelTerm(0, longint'($signed(in_a)), longint'($signed(in_b)), in_last);
        if (acc1) modelTerm(1, longint'($signed(in_a)), longint'($signed(in_b)), in_last);
        lastAccepted = acc0;
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        clearModel();
        #1;
        checkOutput("rst_out_valid24", outValid24, 0);
        checkOutput("rst_out_valid16", outValid16, 0);
        checkOutput("rst_out_sum24", outSum24, 0);
        checkOutput("rst_out_count24", outCount24, 0);
        checkOutput("rst_out_overflow24", outOverflow24, 0);
        checkOutput("rst_in_ready24", inReady24, 1);
    endtask

    function automatic int pickOperand();
        case ($urandom_range(7))
            0: return -128;
            1: return 127;
            default: return int'($urandom_range(255)) - 128;
        endcase
    endfunction

    initial begin
        bit pend;
        int pa, pb;
        bit pl;

        doReset(2);

        $display("[TB] single term");
        applyStimulus(1, -128, -128, 1, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("single_not_early", outValid24, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("single_valid", outValid24, 1);
        checkOutput("single_sum", longint'($signed(outSum24)), 16384);
        checkOutput("single_count", outCount24, 1);
        checkOutput("single_ovf", outOverflow24, 0);
        applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] four-term back-to-back");
        applyStimulus(1, 3, 4, 0, 1);
        applyStimulus(1, -5, 6, 0, 1);
        applyStimulus(1, 127, -128, 0, 1);
        applyStimulus(1, -1, -1, 1, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("four_sum", longint'($signed(outSum24)), -16273);
        checkOutput("four_count", outCount24, 4);
        applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] overflow at 16 bits");
        applyStimulus(1, -128, -128, 0, 1);
        applyStimulus(1, -128, -128, 1, 1);
        applyStimulus(1, 1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("ovf16_sum", longint'($signed(outSum16)), -32768);
        checkOutput("ovf16_flag", outOverflow16, 1);
        checkOutput("ovf24_flag", outOverflow24, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("next16_valid", outValid16, 1);
        checkOutput("next16_sum", longint'($signed(outSum16)), 1);
        checkOutput("next16_flag", outOverflow16, 0);
        applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] backpressure");
        applyStimulus(1, 5, 5, 1, 0);
        applyStimulus(1, 1, 2, 0, 0);
        checkOutput("bp_ready_t1", inReady24, 1);
        applyStimulus(1, 3, 4, 0, 0);
        checkOutput("bp_ready_t2", inReady24, 1);
        applyStimulus(1, -7, 9, 1, 0);
        checkOutput("bp_ready_t3", inReady24, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("bp_ready_stalled", inReady24, 0);
            checkOutput("bp_first_held", longint'($signed(outSum24)), 25);
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("bp_ready_release", inReady24, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("bp_second_valid", outValid24, 1);
        checkOutput("bp_second_sum", longint'($signed(outSum24)), -49);
        checkOutput("bp_second_count", outCount24, 3);

        $display("[TB] reset mid-vector");
        applyStimulus(1, 10, 10, 0, 1);
        applyStimulus(1, 20, 20, 0, 1);
        doReset(1);
        applyStimulus(1, 2, 3, 1, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rstmid_sum", longint'($signed(outSum24)), 6);
        checkOutput("rstmid_count", outCount24, 1);
        applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] long vector, count saturation");
        for (int i = 0; i < 520; i++) begin
            applyStimulus(1, -128, -128, i == 519, 1);
        end
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("long_count24", outCount24, 255);
        checkOutput("long_ovf24", outOverflow24, 1);
        checkOutput("long_sum24", longint'($signed(outSum24)), -8257536);
        checkOutput("long_sum16", longint'($signed(outSum16)), 0);
        applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] random stream");
        pend = 1'b0;
        pa = 0;
        pb = 0;
        pl = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!pend && $urandom_range(3) != 0) begin
                pend = 1'b1;
                pa = pickOperand();
                pb = pickOperand();
                pl = ($urandom_range(4) == 0);
            end
            applyStimulus(pend, pa, pb, pl, $urandom_range(2) != 0);
            if (pend && lastAccepted) pend = 1'b0;
        end
        for (int c = 0; c < 20 && (q0.size() != 0 || q1.size() != 0); c++) begin
            applyStimulus(0, 0, 0, 0, 1);
        end
        checkOutput("drain_w24", q0.size(), 0);
        checkOutput("drain_w16", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac8_signed_dot.md
# mac8_signed_dot

Streaming signed dot-product engine directly downstream of the team's combinational 8x8 signed multiplier, `multiply8_signed_structural`. It accepts a stream of signed 8-bit operand pairs over a valid/ready handshake and registers each pair into an internal multiplier instance. It sign-extends and accumulates the 16-bit two's-complement products, then emits one registered sum per vector, delimited by `in_last`.

## Interface
- `ACC_W`, default 24: accumulator and result width in bits; legal range 16..32.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: an operand pair is offered.
- `in_ready` output 1: the block can accept a pair this cycle.
- `in_a` input 8: signed multiplicand.
- `in_b` input 8: signed multiplier.
- `in_last` input 1: the offered pair is the final term of the current vector.
- `out_valid` output 1: a result is held on the outputs.
- `out_ready` input 1: the consumer takes the result this cycle.
- `out_sum` output ACC_W: signed dot-product result.
- `out_count` output 8: number of terms in the vector; saturates at 255.
- `out_overflow` output 1: sticky flag; at least one signed accumulate in the vector overflowed ACC_W.

## Operation
- **Handshake rules**
  - A transfer happens on any cycle where `in_valid & in_ready` is high.
  - A result is consumed on any cycle where `out_valid & out_ready` is high.
- **Stage 1 (operand register)**
  - On a transfer, load `a_q`, `b_q` and `last_q`, and set `v1` = 1.
  - Otherwise, unless stalled, clear `v1` = 0.
  - `a_q` and `b_q` drive the multiplier instance, whose output is `prod[15:0]`.
- **Stage 2 (accumulate)**
  - Runs when `v1` = 1 and the block is not stalled.
  - `sum_next` = `acc` + `prod` sign-extended to ACC_W, with wrap-around (modulo 2^ACC_W).
  - Overflow is detected when both operands have the same sign and `sum_next` has the opposite sign. It is ORed into the sticky `ovf` flag.
  - `cnt` increments and saturates at 255.
- **End of vector**
  - If `last_q` = 1: load `out_sum` = `sum_next`, `out_count` = `cnt`+1 (saturating), and `out_overflow` = `ovf` | the current overflow. Set `out_valid` = 1.
  - In the same edge, clear `acc`, `cnt` and `ovf` to 0, so the next vector starts clean with no bubble.
  - If `last_q` = 0: update `acc`, `cnt` and `ovf` only.
- **Stall**
  - `stall` = `v1 & last_q & out_valid & ~out_ready`.
  - While stalled, stage 1 holds its contents and `in_ready` = 0.
  - Non-last terms keep accumulating even while a result waits on the output.
- **Output register**
  - `out_valid` clears on consumption unless a new result loads in the same edge. A new result wins.
  - `out_sum`, `out_count` and `out_overflow` are stable while `out_valid` = 1 and `out_ready` = 0.
- **Combinational path:** `in_ready` = `~stall`. There is no combinational path from `in_valid` to `in_ready`.
- **Reset**
  - Clears `v1`, `acc`, `cnt`, `ovf`, `out_valid`, `out_sum`, `out_count` and `out_overflow` to 0.
  - Any partially accumulated vector is discarded.
  - `in_ready` = 1 in the first cycle after reset.

## Timing
- **Throughput:** one pair per cycle when not stalled.
- **Latency:** if the last pair transfers at edge k, `out_valid` = 1 after edge k+1 (2-cycle latency).
- **Single-term vector:** `in_last` = 1 on the first pair gives `out_count` = 1.
- **Simultaneous events:** when consumption and a new result occur on the same edge, `out_valid` stays 1 and the data updates.
- **Zero-length vectors:** do not exist; every vector has at least one term.

## Test plan
- **Single term:** after reset, send (-128,-128, last) -> 2 cycles later `out_sum` = 16384, `out_count` = 1, `out_overflow` = 0.
- **Four-term vector, back-to-back:** send (3,4), (-5,6), (127,-128), (-1,-1 last) on 4 consecutive cycles -> `out_sum` = -16273, `out_count` = 4.
- **Overflow with ACC_W=16:** send (-128,-128), (-128,-128 last) -> `out_sum` = -32768 (0x8000), `out_overflow` = 1. The next vector (1,1 last) gives `out_sum` = 1, `out_overflow` = 0.
- **Backpressure:** hold `out_ready` = 0 after the first result, then stream a second vector of three terms ending in last.
  - Required: the first result stays stable.
  - Required: `in_ready` drops to 0 only while the second vector's last term sits in stage 1.
  - On raising `out_ready`, both results appear in order and no term is lost.
- **Reset mid-vector:** send (10,10), (20,20), assert `rst` for 1 cycle, then send (2,3 last) -> `out_sum` = 6, `out_count` = 1, and the earlier terms are discarded.
